traffic_light_ctrl: RTL and testbench

Single-clock, parametrised two-way intersection controller: phase FSM, countdown timer, optional pedestrian request, and a multiplexed active-low 7-segment scanner for NUM_DIGITS digits. It replaces separate slow/fast clock generators and a ripple digit counter with clock-enable prescalers in one domain. It sits directly under the board top-level, driving RGB_LED, SEG7OUT, AN and DP.

---
 rtl/traffic_pkg.sv | 97 +++++++++
 rtl/traffic_light_ctrl_seven_seg_scan.sv | 86 ++++++++
 rtl/traffic_light_ctrl.sv | 168 ++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: shared definitions for the traffic light controller.
//   - phase_t: phase encoding 0..6 (also the glyph shown on digit 2)
//   - RGB_* : RGB_LED patterns {NS R,G,B, EW R,G,B}
//   - GLYPH_*: active-low 7-segment patterns, literal order a..g
//   - next_phase / rgb_of / glyph_of / bin_to_bcd helpers
package traffic_pkg;

  localparam int REMAIN_W = 7;
  localparam int PHASE_W  = 3;
  localparam int RGB_W    = 6;
  localparam int SEG_W    = 7;

  typedef enum logic [PHASE_W-1:0] {
    PH_NS_GREEN  = 3'd0,
    PH_NS_YELLOW = 3'd1,
    PH_ALL_RED_A = 3'd2,
    PH_EW_GREEN  = 3'd3,
    PH_EW_YELLOW = 3'd4,
    PH_ALL_RED_B = 3'd5,
    PH_FLASH     = 3'd6
  } phase_t;

  localparam logic [RGB_W-1:0] RGB_NS_GREEN  = 6'b010_100;
  localparam logic [RGB_W-1:0] RGB_NS_YELLOW = 6'b110_100;
  localparam logic [RGB_W-1:0] RGB_ALL_RED   = 6'b100_100;
  localparam logic [RGB_W-1:0] RGB_EW_GREEN  = 6'b100_010;
  localparam logic [RGB_W-1:0] RGB_EW_YELLOW = 6'b100_110;
  localparam logic [RGB_W-1:0] RGB_FLASH_ON  = 6'b110_110;
  localparam logic [RGB_W-1:0] RGB_DARK      = 6'b000_000;

  // Segment literals read left to right as a,b,c,d,e,f,g; 0 = segment lit.
  localparam logic [0:SEG_W-1] GLYPH_0     = 7'b0000001;
  localparam logic [0:SEG_W-1] GLYPH_1     = 7'b1001111;
  localparam logic [0:SEG_W-1] GLYPH_2     = 7'b0010010;
  localparam logic [0:SEG_W-1] GLYPH_3     = 7'b0000110;
  localparam logic [0:SEG_W-1] GLYPH_4     = 7'b1001100;
  localparam logic [0:SEG_W-1] GLYPH_5     = 7'b0100100;
  localparam logic [0:SEG_W-1] GLYPH_6     = 7'b0100000;
  localparam logic [0:SEG_W-1] GLYPH_7     = 7'b0001111;
  localparam logic [0:SEG_W-1] GLYPH_8     = 7'b0000000;
  localparam logic [0:SEG_W-1] GLYPH_9     = 7'b0000100;
  localparam logic [0:SEG_W-1] GLYPH_DASH  = 7'b1111110;
  localparam logic [0:SEG_W-1] GLYPH_BLANK = 7'b1111111;

  function automatic phase_t next_phase(input phase_t p);
    case (p)
      PH_NS_GREEN:  return PH_NS_YELLOW;
      PH_NS_YELLOW: return PH_ALL_RED_A;
      PH_ALL_RED_A: return PH_EW_GREEN;
      PH_EW_GREEN:  return PH_EW_YELLOW;
      PH_EW_YELLOW: return PH_ALL_RED_B;
      default:      return PH_NS_GREEN;
    endcase
  endfunction

  function automatic logic [RGB_W-1:0] rgb_of(input phase_t p, input logic flash_on);
    case (p)
      PH_NS_GREEN:  return RGB_NS_GREEN;
      PH_NS_YELLOW: return RGB_NS_YELLOW;
      PH_EW_GREEN:  return RGB_EW_GREEN;
      PH_EW_YELLOW: return RGB_EW_YELLOW;
      PH_FLASH:     return flash_on ? RGB_FLASH_ON : RGB_DARK;
      default:      return RGB_ALL_RED;
    endcase
  endfunction

  function automatic logic [0:SEG_W-1] glyph_of(input logic [3:0] d);
    case (d)
      4'd0:    return GLYPH_0;
      4'd1:    return GLYPH_1;
      4'd2:    return GLYPH_2;
      4'd3:    return GLYPH_3;
      4'd4:    return GLYPH_4;
      4'd5:    return GLYPH_5;
      4'd6:    return GLYPH_6;
      4'd7:    return GLYPH_7;
      4'd8:    return GLYPH_8;
      4'd9:    return GLYPH_9;
      default: return GLYPH_BLANK;
    endcase
  endfunction

  // Restoring compare/subtract on weights 80/40/20/10; valid for v <= 99.
  // Returns {tens, units}.
  function automatic logic [7:0] bin_to_bcd(input logic [REMAIN_W-1:0] v);
    logic [REMAIN_W-1:0] r;
    logic [3:0]          t;
    r = v;
    t = 4'd0;
    if (r >= 7'd80) begin r = r - 7'd80; t = t + 4'd8; end
    if (r >= 7'd40) begin r = r - 7'd40; t = t + 4'd4; end
    if (r >= 7'd20) begin r = r - 7'd20; t = t + 4'd2; end
    if (r >= 7'd10) begin r = r - 7'd10; t = t + 4'd1; end
    return {t, r[3:0]};
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_seven_seg_scan.sv
// seven_seg_scan: multiplexed active-low 7-segment scanner.
//   clk, srst        : clock, synchronous active-high reset
//   tens, units      : BCD of the remaining seconds
//   phase_code       : phase number shown on digit 2
//   flash            : show '-' on digits 0 and 1
//   an[NUM_DIGITS]   : registered anodes, active low
//   seg[0:6]         : registered segments a..g, active low
// Digit 0 = units, digit 1 = tens (blank when zero), digit 2 = phase code.
// Digits 3 and above are unused: their anode stays high and segments blank.
module seven_seg_scan
  import traffic_pkg::*;
#(
  parameter int              SCAN_DIV   = 100_000,
  parameter int              NUM_DIGITS = 8,
  parameter logic [0:SEG_W-1] RESET_SEG = GLYPH_BLANK
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [3:0]            tens,
  input  logic [3:0]            units,
  input  logic [PHASE_W-1:0]    phase_code,
  input  logic                  flash,
  output logic [NUM_DIGITS-1:0] an,
  output logic [0:SEG_W-1]      seg
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = $clog2(NUM_DIGITS);

  logic [SCAN_W-1:0]     scan_cnt_reg;
  logic [IDX_W-1:0]      scan_idx_reg;
  logic                  scan_step;
  logic [NUM_DIGITS-1:0] an_reg;
  logic [NUM_DIGITS-1:0] an_next;
  logic [0:SEG_W-1]      seg_reg;
  logic [0:SEG_W-1]      seg_next;

  assign scan_step = (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1));

  always_ff @(posedge clk) begin
    if (srst) begin
      scan_cnt_reg <= '0;
      scan_idx_reg <= '0;
      an_reg       <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
      seg_reg      <= RESET_SEG;
    end else begin
      scan_cnt_reg <= scan_step ? '0 : scan_cnt_reg + SCAN_W'(1);
      if (scan_step) begin
        scan_idx_reg <= (scan_idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0
                                                                 : scan_idx_reg + IDX_W'(1);
      end
      an_reg  <= an_next;
      seg_reg <= seg_next;
    end
  end

  // Only the three lowest digits ever light.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
      if (gi < 3) begin : g_live
        assign an_next[gi] = (scan_idx_reg != IDX_W'(gi));
      end else begin : g_idle
        assign an_next[gi] = 1'b1;
      end
    end
  endgenerate

  always_comb begin
    seg_next = GLYPH_BLANK;
    if (scan_idx_reg == IDX_W'(0)) begin
      seg_next = flash ? GLYPH_DASH : glyph_of(units);
    end else if (scan_idx_reg == IDX_W'(1)) begin
      if (flash)
        seg_next = GLYPH_DASH;
      else if (tens != 4'd0)
        seg_next = glyph_of(tens);
    end else if (scan_idx_reg == IDX_W'(2)) begin
      seg_next = glyph_of({1'b0, phase_code});
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;

endmodule

// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl: two-way intersection controller in one clock domain.
//   inputCLK : sole clock          RST     : synchronous active-high reset
//   SW       : run enable (0 = flashing yellow), asynchronous, synchronised here
//   PED_REQ  : pedestrian request, used only when TRAFFIC_PED_REQ_EN is defined
//   RGB_LED  : {NS R,G,B, EW R,G,B}, registered
//   SEG7OUT  : segments a..g, active low, registered
//   AN       : digit anodes, active low, registered
//   DP       : decimal point, always off (1)
// Optional feature macro: TRAFFIC_PED_REQ_EN (pedestrian request shortens green).
module traffic_light_ctrl
  import traffic_pkg::*;
#(
  parameter int TICK_DIV   = 100_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int NUM_DIGITS = 8,
  parameter int GREEN_S    = 10,
  parameter int YELLOW_S   = 3,
  parameter int ALLRED_S   = 1,
  parameter int PED_MIN_S  = 3
) (
  input  logic                  inputCLK,
  input  logic                  RST,
  input  logic                  SW,
  input  logic                  PED_REQ,
  output logic [RGB_W-1:0]      RGB_LED,
  output logic [0:SEG_W-1]      SEG7OUT,
  output logic [NUM_DIGITS-1:0] AN,
  output logic                  DP
);

  localparam int TICK_W = $clog2(TICK_DIV);

  logic [TICK_W-1:0]   tick_cnt_reg;
  logic                tick;
  // The synchroniser carries the inverted switch so that its reset value of 0
  // means "run" and reset does not bounce the controller through FLASH.
  logic                flash_req_meta_reg;
  logic                flash_req_sync_reg;
  logic                sw_s;
  phase_t              phase_reg, phase_next;
  logic [REMAIN_W-1:0] remain_reg, remain_next;
  logic                flash_tog_reg, flash_tog_next;
  logic [RGB_W-1:0]    rgb_reg;
  logic                ped_shorten;
  logic [7:0]          bcd;

  function automatic logic [REMAIN_W-1:0] dur_of(input phase_t p);
    case (p)
      PH_NS_GREEN, PH_EW_GREEN:   return REMAIN_W'(GREEN_S);
      PH_NS_YELLOW, PH_EW_YELLOW: return REMAIN_W'(YELLOW_S);
      default:                    return REMAIN_W'(ALLRED_S);
    endcase
  endfunction

  assign tick = (tick_cnt_reg == TICK_W'(TICK_DIV - 1));
  assign sw_s = ~flash_req_sync_reg;

  always_ff @(posedge inputCLK) begin
    if (RST) begin
      tick_cnt_reg       <= '0;
      flash_req_meta_reg <= 1'b0;
      flash_req_sync_reg <= 1'b0;
      phase_reg          <= PH_NS_GREEN;
      remain_reg         <= REMAIN_W'(GREEN_S);
      flash_tog_reg      <= 1'b0;
      rgb_reg            <= RGB_NS_GREEN;
    end else begin
      tick_cnt_reg       <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
      flash_req_meta_reg <= ~SW;
      flash_req_sync_reg <= flash_req_meta_reg;
      phase_reg          <= phase_next;
      remain_reg         <= remain_next;
      flash_tog_reg      <= flash_tog_next;
      rgb_reg            <= rgb_of(phase_reg, flash_tog_reg);
    end
  end

  // Leaving run mode takes priority over a coinciding tick.
  always_comb begin
    phase_next     = phase_reg;
    remain_next    = remain_reg;
    flash_tog_next = flash_tog_reg;
    if (!sw_s) begin
      if (phase_reg != PH_FLASH) begin
        phase_next     = PH_FLASH;
        flash_tog_next = 1'b0;
      end else if (tick) begin
        flash_tog_next = ~flash_tog_reg;
      end
    end else if (phase_reg == PH_FLASH) begin
      phase_next     = PH_ALL_RED_B;
      remain_next    = REMAIN_W'(ALLRED_S);
      flash_tog_next = 1'b0;
    end else if (tick) begin
      if (remain_reg == REMAIN_W'(1)) begin
        phase_next  = next_phase(phase_reg);
        remain_next = dur_of(next_phase(phase_reg));
      end else if (ped_shorten) begin
        remain_next = REMAIN_W'(PED_MIN_S);
      end else begin
        remain_next = remain_reg - REMAIN_W'(1);
      end
    end
  end

`ifdef TRAFFIC_PED_REQ_EN
  logic ped_meta_reg, ped_sync_reg, ped_prev_reg;
  logic ped_latch_reg, ped_latch_next;
  logic ped_rise, ped_clear;

  assign ped_rise  = ped_sync_reg & ~ped_prev_reg;
  assign ped_clear = (phase_next != phase_reg) &&
                     ((phase_next == PH_ALL_RED_A) || (phase_next == PH_ALL_RED_B) ||
                      (phase_next == PH_FLASH));

  // A fresh request wins over a same-cycle clear so it is never dropped.
  always_comb begin
    ped_latch_next = ped_latch_reg;
    if (ped_rise)
      ped_latch_next = 1'b1;
    else if (ped_clear)
      ped_latch_next = 1'b0;
  end

  always_ff @(posedge inputCLK) begin
    if (RST) begin
      ped_meta_reg  <= 1'b0;
      ped_sync_reg  <= 1'b0;
      ped_prev_reg  <= 1'b0;
      ped_latch_reg <= 1'b0;
    end else begin
      ped_meta_reg  <= PED_REQ;
      ped_sync_reg  <= ped_meta_reg;
      ped_prev_reg  <= ped_sync_reg;
      ped_latch_reg <= ped_latch_next;
    end
  end

  assign ped_shorten = ped_latch_reg &&
                       ((phase_reg == PH_NS_GREEN) || (phase_reg == PH_EW_GREEN)) &&
                       (remain_reg > REMAIN_W'(PED_MIN_S));
`else
  logic ped_req_unused;
  assign ped_req_unused = PED_REQ;
  assign ped_shorten    = 1'b0;
`endif

  assign bcd = bin_to_bcd(remain_reg);

  seven_seg_scan #(
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS),
    .RESET_SEG  (glyph_of(4'(GREEN_S % 10)))
  ) u_scan (
    .clk        (inputCLK),
    .srst       (RST),
    .tens       (bcd[7:4]),
    .units      (bcd[3:0]),
    .phase_code (phase_reg),
    .flash      (phase_reg == PH_FLASH),
    .an         (AN),
    .seg        (SEG7OUT)
  );

  assign RGB_LED = rgb_reg;
  assign DP      = 1'b1;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with TICK_DIV=4, SCAN_DIV=2,
// GREEN_S=5, YELLOW_S=2, ALLRED_S=1, PED_MIN_S=2, NUM_DIGITS=8.
// Time base: edge 0 is the last rising edge with RST high; phase/remain
// update on tick edges 4n, registered outputs follow one edge later.
module tb_traffic_light_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw;
  logic       ped_req;
  logic [5:0] rgb;
  logic [0:6] seg;
  logic [7:0] an;
  logic       dp;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Bench-owned glyph table, a..g left to right, active low.
  localparam logic [6:0] G0    = 7'b0000001;
  localparam logic [6:0] G1    = 7'b1001111;
  localparam logic [6:0] G3    = 7'b0000110;
  localparam logic [6:0] G5    = 7'b0100100;
  localparam logic [6:0] G6    = 7'b0100000;
  localparam logic [6:0] DASH  = 7'b1111110;
  localparam logic [6:0] BLANK = 7'b1111111;

  localparam logic [5:0] NS_G = 6'b010_100;
  localparam logic [5:0] NS_Y = 6'b110_100;
  localparam logic [5:0] RED  = 6'b100_100;
  localparam logic [5:0] EW_G = 6'b100_010;
  localparam logic [5:0] EW_Y = 6'b100_110;
  localparam logic [5:0] FL_ON = 6'b110_110;
  localparam logic [5:0] DARK = 6'b000_000;

`ifdef TRAFFIC_PED_REQ_EN
  localparam int Y_EDGE = 80;  // request shortens the second NS green
`else
  localparam int Y_EDGE = 84;
`endif

  traffic_light_ctrl #(
    .TICK_DIV   (4),
    .SCAN_DIV   (2),
    .NUM_DIGITS (8),
    .GREEN_S    (5),
    .YELLOW_S   (2),
    .ALLRED_S   (1),
    .PED_MIN_S  (2)
  ) dut (
    .inputCLK (clk),
    .RST      (rst),
    .SW       (sw),
    .PED_REQ  (ped_req),
    .RGB_LED  (rgb),
    .SEG7OUT  (seg),
    .AN       (an),
    .DP       (dp)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end else begin
      $display("[TB] ok   %s @cyc %0d: %0h", tag, cyc, got);
    end
  endtask

  // Advance to 1 time unit after edge e (relative to reset release).
  task automatic run_to(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; sw = 1'b1; ped_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;

    // Reset state
    check_eq("rst_rgb", 32'(rgb), 32'(NS_G));
    check_eq("rst_an",  32'(an),  32'h0FE);
    check_eq("rst_seg", 32'(seg), 32'(G5));
    check_eq("rst_dp",  32'(dp),  32'd1);

    // Scan order and digit contents at remain=5 in NS_GREEN
    run_to(3);  check_eq("scan_d1_an", 32'(an), 32'h0FD);
                check_eq("scan_d1_blank", 32'(seg), 32'(BLANK));
    run_to(5);  check_eq("scan_d2_an", 32'(an), 32'h0FB);
                check_eq("scan_d2_phase0", 32'(seg), 32'(G0));
    run_to(7);  check_eq("scan_d3_an_off", 32'(an), 32'h0FF);
                check_eq("scan_d3_blank", 32'(seg), 32'(BLANK));
    run_to(17); check_eq("scan_wrap_an", 32'(an), 32'h0FE);
                check_eq("remain1_units", 32'(seg), 32'(G1));

    // Phase sequence
    run_to(20); check_eq("ns_green_t4", 32'(rgb), 32'(NS_G));
    run_to(21); check_eq("ns_yellow_t5", 32'(rgb), 32'(NS_Y));
    run_to(28); check_eq("ns_yellow_t6", 32'(rgb), 32'(NS_Y));
    run_to(29); check_eq("all_red_a_t7", 32'(rgb), 32'(RED));
    run_to(33); check_eq("ew_green_t8", 32'(rgb), 32'(EW_G));
                check_eq("ew_remain5", 32'(seg), 32'(G5));
    run_to(37); check_eq("ew_phase3", 32'(seg), 32'(G3));
    run_to(53); check_eq("ew_yellow", 32'(rgb), 32'(EW_Y));
    run_to(61); check_eq("all_red_b", 32'(rgb), 32'(RED));
    run_to(65); check_eq("back_ns_green", 32'(rgb), 32'(NS_G));
                check_eq("back_remain5", 32'(seg), 32'(G5));

    // Pedestrian request pulse at NS_GREEN remain=5
    run_to(66); ped_req = 1'b1;
    run_to(68); ped_req = 1'b0;
    run_to(Y_EDGE);     check_eq("ped_green_end", 32'(rgb), 32'(NS_G));
    run_to(Y_EDGE + 1); check_eq("ped_yellow", 32'(rgb), 32'(NS_Y));
    // EW green must run its full length (latch cleared at ALL_RED_A)
    run_to(105);        check_eq("ew_green_full", 32'(rgb), 32'(EW_G));

    // Flash: sw_s falls in the cycle ending at tick edge 108
    sw = 1'b0;
    run_to(108); check_eq("flash_pending", 32'(rgb), 32'(EW_G));
    run_to(109); check_eq("flash_dark0", 32'(rgb), 32'(DARK));
    run_to(113); check_eq("flash_on1", 32'(rgb), 32'(FL_ON));
                 check_eq("flash_dash_d0", 32'(seg), 32'(DASH));
    run_to(115); check_eq("flash_dash_d1", 32'(seg), 32'(DASH));
    run_to(117); check_eq("flash_dark2", 32'(rgb), 32'(DARK));
                 check_eq("flash_phase6", 32'(seg), 32'(G6));
    run_to(118); sw = 1'b1;
    run_to(121); check_eq("flash_on3", 32'(rgb), 32'(FL_ON));
    run_to(122); check_eq("exit_all_red_b", 32'(rgb), 32'(RED));
    run_to(124); check_eq("all_red_b_hold", 32'(rgb), 32'(RED));
    run_to(125); check_eq("exit_ns_green", 32'(rgb), 32'(NS_G));

    // Reset during NS_YELLOW, mid-scan
    run_to(147); check_eq("pre_rst_yellow", 32'(rgb), 32'(NS_Y));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("mid_rst_rgb", 32'(rgb), 32'(NS_G));
    check_eq("mid_rst_an",  32'(an),  32'h0FE);
    check_eq("mid_rst_seg", 32'(seg), 32'(G5));
    rst = 1'b0;
    cyc = 0;
    run_to(3);  check_eq("post_rst_an", 32'(an), 32'h0FD);
    run_to(20); check_eq("post_rst_green", 32'(rgb), 32'(NS_G));
    run_to(21); check_eq("post_rst_yellow", 32'(rgb), 32'(NS_Y));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
